// File: rtl/width_reductor_arbiter.sv
// Round-robin arbiter in front of a shared serializer: the granted requester's
// first `active` elements (clamped to NO) leave one per beat, tagged with source index and last.
module width_reductor_arbiter #(
  parameter int N_IN     = 4,
  parameter int W_DATA   = 16,
  parameter int NO       = 4,
  parameter int W_ACTIVE = 3,
  parameter int W_IDX    = $clog2(N_IN)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_IN-1:0]                           din_valid,
  output logic [N_IN-1:0]                           din_ready,
  input  logic [N_IN-1:0][W_ACTIVE+NO*W_DATA-1:0]   din_data,
  output logic                                      dout_valid,
  input  logic                                      dout_ready,
  output logic [W_IDX+W_DATA:0]                     dout_data,
  output logic                                      dbg_state
);

  // Handshake: a transfer happens on any cycle where valid & ready are both high;
  // once dout_valid rises it stays high with stable data until that transfer.

  localparam int W_CNT = (NO > 2) ? $clog2(NO) : 1;
  localparam int W_VEC = W_ACTIVE + NO * W_DATA;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [W_IDX-1:0]    grant, grant_nxt;
  logic [W_IDX-1:0]    ptr, ptr_nxt;
  logic [W_CNT-1:0]    cnt, cnt_nxt;
  logic [W_ACTIVE-1:0] len, len_nxt;

  logic                      found;
  logic [W_IDX-1:0]          win;
  logic [W_ACTIVE-1:0]       win_act;
  logic [W_ACTIVE-1:0]       eff;
  logic [NO-1:0][W_DATA-1:0] g_elems;
  logic [W_DATA-1:0]         elem;
  logic                      last;

  function automatic logic [W_IDX-1:0] next_idx(input logic [W_IDX-1:0] i);
    if (int'(i) == N_IN - 1) return '0;
    else return i + 1'b1;
  endfunction

  // First valid channel at or after ptr, wrapping modulo N_IN.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (!found && din_valid[(int'(ptr) + k) % N_IN]) begin
        found = 1'b1;
        win   = W_IDX'((int'(ptr) + k) % N_IN);
      end
    end
  end

  assign win_act = din_data[win][W_VEC-1 -: W_ACTIVE];
  assign eff     = (win_act > W_ACTIVE'(NO)) ? W_ACTIVE'(NO) : win_act;

  assign g_elems = din_data[grant][NO*W_DATA-1:0];
  assign elem    = g_elems[cnt];
  assign last    = (W_ACTIVE'(cnt) == len - W_ACTIVE'(1));

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    len_nxt    = len;
    din_ready  = '0;
    dout_valid = 1'b0;
    dout_data  = {grant, last, elem};
    case (state)
      IDLE: begin
        if (found) begin
          if (eff == '0) begin
            // Zero-length request is acknowledged without ever reaching BUSY.
            din_ready[win] = 1'b1;
            ptr_nxt        = next_idx(win);
          end else begin
            grant_nxt = win;
            cnt_nxt   = '0;
            len_nxt   = eff;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (last) begin
            din_ready[grant] = 1'b1;
            cnt_nxt          = '0;
            ptr_nxt          = next_idx(grant);
            state_nxt        = IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset cycle must show no handshake on either side.
    if (rst) begin
      din_ready  = '0;
      dout_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
    end
  end

  assign dbg_state = (state == BUSY);

endmodule

// File: tb/tb_width_reductor_arbiter.sv
// Directed cycle-by-cycle bench for width_reductor_arbiter: a vector table for the
// arbitration/serialization cases plus hand-written reset-abort and wrap sequences.
module tb_width_reductor_arbiter;

  localparam int N_IN = 4, W_DATA = 16, NO = 4, W_ACTIVE = 3, W_IDX = 2;

  logic                                    clk = 1'b0;
  logic                                    rst;
  logic [N_IN-1:0]                         din_valid;
  logic [N_IN-1:0]                         din_ready;
  logic [N_IN-1:0][W_ACTIVE+NO*W_DATA-1:0] din_data;
  logic                                    dout_valid;
  logic                                    dout_ready;
  logic [W_IDX+W_DATA:0]                   dout_data;
  logic                                    dbg_state;

  width_reductor_arbiter #(
    .N_IN(N_IN), .W_DATA(W_DATA), .NO(NO), .W_ACTIVE(W_ACTIVE)
  ) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int          seg;
    logic        r;
    logic [3:0]  vld;
    logic        rdy;
    logic        ev;
    logic [1:0]  eidx;
    logic        el;
    logic [15:0] ee;
    logic [3:0]  er;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input int seg, input logic r, input logic [3:0] vld, input logic rdy,
                     input logic ev, input logic [1:0] eidx, input logic el,
                     input logic [15:0] ee, input logic [3:0] er);
    vec_t v;
    v.seg = seg; v.r = r; v.vld = vld; v.rdy = rdy;
    v.ev = ev; v.eidx = eidx; v.el = el; v.ee = ee; v.er = er;
    tbl.push_back(v);
  endtask

  // Driver tasks
  task automatic set_ch(input int ch, input logic [2:0] act, input logic [15:0] e0,
                        input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    din_data[ch] = {act, e3, e2, e1, e0};
  endtask

  task automatic drive(input logic r, input logic [3:0] vld, input logic rdy);
    @(negedge clk);
    rst        = r;
    din_valid  = vld;
    dout_ready = rdy;
    #1;
  endtask

  task automatic load_seg(input int seg);
    for (int c = 0; c < N_IN; c++) set_ch(c, 3'd1, 16'hffff, 16'hffff, 16'hffff, 16'hffff);
    case (seg)
      0: set_ch(0, 3'd3, 16'd1, 16'd2, 16'd3, 16'd0);
      1: for (int c = 0; c < N_IN; c++) set_ch(c, 3'd1, 16'(10 + c), 16'd0, 16'd0, 16'd0);
      2: set_ch(2, 3'd2, 16'd20, 16'd21, 16'd0, 16'd0);
      3: begin
        set_ch(1, 3'd0, 16'd99, 16'd99, 16'd99, 16'd99);
        set_ch(2, 3'd7, 16'd30, 16'd31, 16'd32, 16'd33);
        set_ch(0, 3'd1, 16'd40, 16'd0, 16'd0, 16'd0);
      end
      default: ;
    endcase
  endtask

  // Scoreboard: expected beats are queued per check and compared against the DUT
  logic [W_IDX+W_DATA:0] exp_q[$];

  task automatic check(input string name, input logic ev, input logic [1:0] eidx,
                       input logic el, input logic [15:0] ee, input logic [3:0] er);
    logic [W_IDX+W_DATA:0] exp_beat;
    n_vec++;
    if (dout_valid !== ev) begin
      n_err++;
      $display("FAIL %s dout_valid got %0b want %0b", name, dout_valid, ev);
    end
    if (din_ready !== er) begin
      n_err++;
      $display("FAIL %s din_ready got %b want %b", name, din_ready, er);
    end
    if (ev) begin
      exp_q.push_back({eidx, el, ee});
      exp_beat = exp_q.pop_front();
      if (dout_data !== exp_beat) begin
        n_err++;
        $display("FAIL %s beat got idx=%0d last=%0b elem=%0d want idx=%0d last=%0b elem=%0d",
                 name, dout_data[17:16], dout_data[16-W_IDX+1], dout_data[15:0],
                 exp_beat[17:16], exp_beat[16], exp_beat[15:0]);
      end
    end
  endtask

  task automatic step(input string name, input logic r, input logic [3:0] vld, input logic rdy,
                      input logic ev, input logic [1:0] eidx, input logic el,
                      input logic [15:0] ee, input logic [3:0] er);
    drive(r, vld, rdy);
    check(name, ev, eidx, el, ee, er);
  endtask

  initial begin
    int cur_seg;
    rst = 1'b1; din_valid = '0; dout_ready = 1'b0; din_data = '0;
    repeat (2) @(posedge clk);

    // seg0: ch0 active=3, data 1,2,3
    add(0, 1, 4'b0001, 1, 0, 0, 0, 0,  4'b0000);
    add(0, 0, 4'b0001, 1, 0, 0, 0, 0,  4'b0000);
    add(0, 0, 4'b0001, 1, 1, 0, 0, 1,  4'b0000);
    add(0, 0, 4'b0001, 1, 1, 0, 0, 2,  4'b0000);
    add(0, 0, 4'b0001, 1, 1, 0, 1, 3,  4'b0001);
    add(0, 0, 4'b0000, 1, 0, 0, 0, 0,  4'b0000);
    // seg1: all four requesting single elements, round-robin with a bubble
    add(1, 1, 4'b0000, 1, 0, 0, 0, 0,  4'b0000);
    add(1, 0, 4'b1111, 1, 0, 0, 0, 0,  4'b0000);
    add(1, 0, 4'b1111, 1, 1, 0, 1, 10, 4'b0001);
    add(1, 0, 4'b1110, 1, 0, 0, 0, 0,  4'b0000);
    add(1, 0, 4'b1110, 1, 1, 1, 1, 11, 4'b0010);
    add(1, 0, 4'b1100, 1, 0, 0, 0, 0,  4'b0000);
    add(1, 0, 4'b1100, 1, 1, 2, 1, 12, 4'b0100);
    add(1, 0, 4'b1000, 1, 0, 0, 0, 0,  4'b0000);
    add(1, 0, 4'b1000, 1, 1, 3, 1, 13, 4'b1000);
    add(1, 0, 4'b0000, 1, 0, 0, 0, 0,  4'b0000);
    add(1, 0, 4'b0011, 1, 0, 0, 0, 0,  4'b0000);
    add(1, 0, 4'b0011, 1, 1, 0, 1, 10, 4'b0001);
    add(1, 0, 4'b0010, 1, 0, 0, 0, 0,  4'b0000);
    add(1, 0, 4'b0010, 1, 1, 1, 1, 11, 4'b0010);
    add(1, 0, 4'b0000, 1, 0, 0, 0, 0,  4'b0000);
    // seg2: ch2 active=2 with dout_ready 1,0,0,1
    add(2, 0, 4'b0100, 1, 0, 0, 0, 0,  4'b0000);
    add(2, 0, 4'b0100, 1, 1, 2, 0, 20, 4'b0000);
    add(2, 0, 4'b0100, 0, 1, 2, 1, 21, 4'b0000);
    add(2, 0, 4'b0100, 0, 1, 2, 1, 21, 4'b0000);
    add(2, 0, 4'b0100, 1, 1, 2, 1, 21, 4'b0100);
    add(2, 0, 4'b0000, 1, 0, 0, 0, 0,  4'b0000);
    // seg3: zero-length on ch1, then ch2 active=7 clamps to 4 beats, then ch0 via wrap
    add(3, 0, 4'b0010, 1, 0, 0, 0, 0,  4'b0010);
    add(3, 0, 4'b0101, 1, 0, 0, 0, 0,  4'b0000);
    add(3, 0, 4'b0101, 1, 1, 2, 0, 30, 4'b0000);
    add(3, 0, 4'b0101, 1, 1, 2, 0, 31, 4'b0000);
    add(3, 0, 4'b0101, 1, 1, 2, 0, 32, 4'b0000);
    add(3, 0, 4'b0101, 1, 1, 2, 1, 33, 4'b0100);
    add(3, 0, 4'b0001, 1, 0, 0, 0, 0,  4'b0000);
    add(3, 0, 4'b0001, 1, 1, 0, 1, 40, 4'b0001);
    add(3, 0, 4'b0000, 1, 0, 0, 0, 0,  4'b0000);

    cur_seg = -1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].seg != cur_seg) begin
        cur_seg = tbl[i].seg;
        @(negedge clk);
        load_seg(cur_seg);
      end
      step($sformatf("seg%0d_v%0d", tbl[i].seg, i), tbl[i].r, tbl[i].vld, tbl[i].rdy,
           tbl[i].ev, tbl[i].eidx, tbl[i].el, tbl[i].ee, tbl[i].er);
    end

    // Reset mid-transaction: ch1 active=4 aborted after one beat, then re-served from elem0
    load_seg(9);
    set_ch(1, 3'd4, 16'd50, 16'd51, 16'd52, 16'd53);
    step("abort_arb",   0, 4'b0010, 1, 0, 0, 0, 0,  4'b0000);
    step("abort_b0",    0, 4'b0010, 1, 1, 1, 0, 50, 4'b0000);
    step("abort_rst",   1, 4'b0010, 1, 0, 0, 0, 0,  4'b0000);
    step("abort_idle",  0, 4'b0010, 1, 0, 0, 0, 0,  4'b0000);
    step("reserve_b0",  0, 4'b0010, 1, 1, 1, 0, 50, 4'b0000);
    step("reserve_b1",  0, 4'b0010, 1, 1, 1, 0, 51, 4'b0000);
    step("reserve_b2",  0, 4'b0010, 1, 1, 1, 0, 52, 4'b0000);
    step("reserve_b3",  0, 4'b0010, 1, 1, 1, 1, 53, 4'b0010);
    step("reserve_end", 0, 4'b0000, 1, 0, 0, 0, 0,  4'b0000);

    // ch3 served, then ch0 and ch3 together: pointer wrapped to 0 so ch0 wins
    set_ch(3, 3'd1, 16'd60, 16'd0, 16'd0, 16'd0);
    set_ch(0, 3'd1, 16'd61, 16'd0, 16'd0, 16'd0);
    step("wrap_arb3",  0, 4'b1000, 1, 0, 0, 0, 0,  4'b0000);
    step("wrap_ch3",   0, 4'b1000, 1, 1, 3, 1, 60, 4'b1000);
    step("wrap_arb",   0, 4'b1001, 1, 0, 0, 0, 0,  4'b0000);
    step("wrap_ch0",   0, 4'b1001, 1, 1, 0, 1, 61, 4'b0001);
    step("wrap_arb3b", 0, 4'b1000, 1, 0, 0, 0, 0,  4'b0000);
    step("wrap_ch3b",  0, 4'b1000, 1, 1, 3, 1, 60, 4'b1000);
    step("wrap_end",   0, 4'b0000, 1, 0, 0, 0, 0,  4'b0000);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
